// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch: drives imem address from pc, queues {pc, instr} in 2 entries toward decode.
// Fetch-to-head 1 cycle; fetch stalls when both entries are full and the head is not being taken.
module imem_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic [31:0] im_addr_o,
    input  logic [31:0] im_data_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        halt_i,
    output logic        id_valid_o,
    input  logic        id_ready_i,
    output logic [31:0] id_instr_o,
    output logic [31:0] id_pc_o,
    output logic        misalign_o
);

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fq_entry_t;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [1:0]  cnt_q;
    fq_entry_t   head_q;
    fq_entry_t   tail_q;

    logic        deq;
    logic        fetch;
    fq_entry_t   new_entry;

    assign deq       = (cnt_q != 2'd0) && id_ready_i;
    // A full queue may still accept a fetch when its head leaves in the same cycle.
    assign fetch     = (state_q == ST_RUN) && !halt_i && !redirect_i &&
                       ((cnt_q != 2'd2) || deq);
    assign new_entry = '{pc: pc_q, instr: im_data_i};

    assign im_addr_o  = {2'b00, pc_q[31:2]};
    assign id_valid_o = (cnt_q != 2'd0);
    assign id_instr_o = head_q.instr;
    assign id_pc_o    = head_q.pc;
    assign misalign_o = redirect_i && (redirect_pc_i[1:0] != 2'b00);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            cnt_q   <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            case (state_q)
                ST_BOOT:   state_q <= halt_i ? ST_HALTED : ST_RUN;
                ST_RUN:    state_q <= halt_i ? ST_HALTED : ST_RUN;
                ST_HALTED: state_q <= halt_i ? ST_HALTED : ST_RUN;
                default:   state_q <= ST_BOOT;
            endcase

            if (redirect_i) begin
                // Flush drops the head even if decode took it this cycle.
                cnt_q <= 2'd0;
                pc_q  <= {redirect_pc_i[31:2], 2'b00};
            end else begin
                if (fetch) begin
                    pc_q <= pc_q + 32'd4;
                end
                case ({fetch, deq})
                    2'b01: begin
                        head_q <= tail_q;
                        cnt_q  <= cnt_q - 2'd1;
                    end
                    2'b10: begin
                        if (cnt_q == 2'd0) begin
                            head_q <= new_entry;
                        end else begin
                            tail_q <= new_entry;
                        end
                        cnt_q <= cnt_q + 2'd1;
                    end
                    2'b11: begin
                        if (cnt_q == 2'd1) begin
                            head_q <= new_entry;
                        end else begin
                            head_q <= tail_q;
                            tail_q <= new_entry;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed vector table, async reset sequence, then random run vs a queue model.
module tb_imem_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] im_addr;
    logic [31:0] im_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        misalign;

    int checks = 0;
    int errors = 0;

    imem_fetch_ctrl #(.RESET_PC(32'h0000_0100)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .im_addr_o     (im_addr),
        .im_data_i     (im_data),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .halt_i        (halt),
        .id_valid_o    (id_valid),
        .id_ready_i    (id_ready),
        .id_instr_o    (id_instr),
        .id_pc_o       (id_pc),
        .misalign_o    (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] idx);
        return (idx * 32'h9E37_79B1) ^ 32'hC0DE_0000 ^ {idx[15:0], idx[31:16]};
    endfunction

    assign im_data = memf(im_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic        rd;
        logic [31:0] rpc;
        logic        hlt;
        logic        rdy;
        logic        e_vld;
        logic [31:0] e_pc;
        logic        e_mis;
        logic [31:0] e_addr;
    } vec_t;

    function automatic vec_t v(input logic rd, input logic [31:0] rpc, input logic hlt,
                               input logic rdy, input logic e_vld, input logic [31:0] e_pc,
                               input logic e_mis, input logic [31:0] e_addr);
        vec_t r;
        r.rd = rd; r.rpc = rpc; r.hlt = hlt; r.rdy = rdy;
        r.e_vld = e_vld; r.e_pc = e_pc; r.e_mis = e_mis; r.e_addr = e_addr;
        return r;
    endfunction

    // Behavioural model: queue of fetched {pc, instr}
    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc;
    logic        m_boot;
    logic        m_prev_halt;

    task automatic model_reset();
        mq.delete();
        m_pc        = 32'h0000_0100;
        m_boot      = 1'b1;
        m_prev_halt = 1'b0;
    endtask

    task automatic model_step();
        ent_t e;
        logic hs;
        logic can_fetch;
        hs        = (mq.size() != 0) && id_ready;
        can_fetch = !m_boot && !halt && !m_prev_halt && !redirect;
        if (redirect) begin
            mq.delete();
            m_pc = {redirect_pc[31:2], 2'b00};
        end else begin
            if (hs) void'(mq.pop_front());
            if (can_fetch && mq.size() < 2) begin
                e.pc  = m_pc;
                e.ins = memf(m_pc >> 2);
                mq.push_back(e);
                m_pc = m_pc + 32'd4;
            end
        end
        m_boot      = 1'b0;
        m_prev_halt = halt;
    endtask

    task automatic model_check();
        chk("rnd_valid", {31'd0, id_valid}, {31'd0, mq.size() != 0});
        chk("rnd_misalign", {31'd0, misalign}, {31'd0, redirect && (redirect_pc[1:0] != 2'b00)});
        chk("rnd_addr", im_addr, m_pc >> 2);
        if (mq.size() != 0) begin
            chk("rnd_pc", id_pc, mq[0].pc);
            chk("rnd_instr", id_instr, mq[0].ins);
        end
    endtask

    vec_t tbl[27];

    initial begin
        tbl[0]  = v(0, 32'h0,         0, 1, 0, 32'h0,         0, 32'h40);
        tbl[1]  = v(0, 32'h0,         0, 1, 0, 32'h0,         0, 32'h40);
        tbl[2]  = v(0, 32'h0,         0, 0, 1, 32'h100,       0, 32'h41);
        tbl[3]  = v(0, 32'h0,         0, 0, 1, 32'h100,       0, 32'h42);
        tbl[4]  = v(0, 32'h0,         0, 0, 1, 32'h100,       0, 32'h42);
        tbl[5]  = v(0, 32'h0,         0, 0, 1, 32'h100,       0, 32'h42);
        tbl[6]  = v(0, 32'h0,         0, 0, 1, 32'h100,       0, 32'h42);
        tbl[7]  = v(0, 32'h0,         0, 1, 1, 32'h100,       0, 32'h42);
        tbl[8]  = v(0, 32'h0,         0, 1, 1, 32'h104,       0, 32'h43);
        tbl[9]  = v(0, 32'h0,         0, 1, 1, 32'h108,       0, 32'h44);
        tbl[10] = v(1, 32'h40,        0, 1, 1, 32'h10C,       0, 32'h45);
        tbl[11] = v(0, 32'h0,         0, 1, 0, 32'h0,         0, 32'h10);
        tbl[12] = v(0, 32'h0,         0, 1, 1, 32'h40,        0, 32'h11);
        tbl[13] = v(1, 32'h42,        0, 1, 1, 32'h44,        1, 32'h12);
        tbl[14] = v(0, 32'h0,         0, 1, 0, 32'h0,         0, 32'h10);
        tbl[15] = v(0, 32'h0,         1, 1, 1, 32'h40,        0, 32'h11);
        tbl[16] = v(0, 32'h0,         1, 1, 0, 32'h0,         0, 32'h11);
        tbl[17] = v(0, 32'h0,         1, 1, 0, 32'h0,         0, 32'h11);
        tbl[18] = v(0, 32'h0,         1, 1, 0, 32'h0,         0, 32'h11);
        tbl[19] = v(0, 32'h0,         0, 1, 0, 32'h0,         0, 32'h11);
        tbl[20] = v(0, 32'h0,         0, 1, 0, 32'h0,         0, 32'h11);
        tbl[21] = v(0, 32'h0,         0, 1, 1, 32'h44,        0, 32'h12);
        tbl[22] = v(1, 32'hFFFF_FFF8, 0, 1, 1, 32'h48,        0, 32'h13);
        tbl[23] = v(0, 32'h0,         0, 1, 0, 32'h0,         0, 32'h3FFF_FFFE);
        tbl[24] = v(0, 32'h0,         0, 1, 1, 32'hFFFF_FFF8, 0, 32'h3FFF_FFFF);
        tbl[25] = v(0, 32'h0,         0, 1, 1, 32'hFFFF_FFFC, 0, 32'h0);
        tbl[26] = v(0, 32'h0,         0, 1, 1, 32'h0000_0000, 0, 32'h1);

        rst_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        halt        = 1'b0;
        id_ready    = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_instr", id_instr, 32'h0);
        chk("rst_pc", id_pc, 32'h0);
        chk("rst_misalign", {31'd0, misalign}, 32'd0);
        chk("rst_addr", im_addr, 32'h40);

        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 27; i++) begin
            redirect    = tbl[i].rd;
            redirect_pc = tbl[i].rpc;
            halt        = tbl[i].hlt;
            id_ready    = tbl[i].rdy;
            @(negedge clk);
            chk($sformatf("tbl%0d_valid", i), {31'd0, id_valid}, {31'd0, tbl[i].e_vld});
            chk($sformatf("tbl%0d_misalign", i), {31'd0, misalign}, {31'd0, tbl[i].e_mis});
            chk($sformatf("tbl%0d_addr", i), im_addr, tbl[i].e_addr);
            if (tbl[i].e_vld) begin
                chk($sformatf("tbl%0d_pc", i), id_pc, tbl[i].e_pc);
                chk($sformatf("tbl%0d_instr", i), id_instr, memf(tbl[i].e_pc >> 2));
            end
            @(posedge clk);
            #1;
        end

        // Mid-stream asynchronous reset: outputs must clear before any clock edge.
        redirect = 1'b0;
        halt     = 1'b0;
        id_ready = 1'b0;
        #1;
        chk("pre_arst_valid", {31'd0, id_valid}, 32'd1);
        chk("pre_arst_pc", id_pc, 32'h4);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, id_valid}, 32'd0);
        chk("arst_instr", id_instr, 32'h0);
        chk("arst_pc", id_pc, 32'h0);
        chk("arst_addr", im_addr, 32'h40);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        id_ready = 1'b1;

        for (int c = 0; c < 4000; c++) begin
            if (c >= 3) begin
                redirect = ($urandom_range(15) == 0);
                case ($urandom_range(3))
                    0: redirect_pc = {22'd0, 8'($urandom_range(255)), 2'b00};
                    1: redirect_pc = $urandom;
                    2: redirect_pc = 32'hFFFF_FFF0 + 32'($urandom_range(15));
                    default: redirect_pc = $urandom & 32'hFFFF_FFFC;
                endcase
                if ($urandom_range(19) == 0) halt = !halt;
                id_ready = ($urandom_range(9) < 7);
            end
            @(negedge clk);
            model_check();
            model_step();
            @(posedge clk);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
